// File: rtl/deserializer_pkg.sv
// Shared types and width helpers for the serial-to-parallel receiver.
package deserializer_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Width of a field that must hold 0..w-1 (at least one bit).
  function automatic int unsigned mod_w(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/deserializer_idle_timer.sv
// Counts consecutive idle cycles while a partial word is held; pulses expire_c
// combinationally on the cycle that reaches TIMEOUT.
module deserializer_idle_timer
  import deserializer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic active_i,
  input  logic clear_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = mod_w(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  assign expire_c = active_i && !clear_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (srst_i || clear_i || !active_i || expire_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver with one-cycle word valid pulse.
// Optional partial-word flush after an idle gap: define DESERIALIZER_TIMEOUT_EN.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned DATA_MOD_WIDTH = mod_w(DATA_BUS_WIDTH),
  parameter int unsigned IDLE_TIMEOUT   = 8
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      data_i,
  input  logic                      data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      busy_o
);

  localparam logic [DATA_MOD_WIDTH-1:0] LAST_CNT = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1);

  state_t                    state_q;
  state_t                    state_nxt;
  logic [DATA_BUS_WIDTH-1:0] sr_q;
  logic [DATA_BUS_WIDTH-1:0] sr_nxt;
  logic [DATA_BUS_WIDTH-1:0] flush_word_c;
  logic [DATA_MOD_WIDTH-1:0] cnt_q;
  logic [DATA_MOD_WIDTH-1:0] cnt_nxt;
  logic                      shift_en_c;
  logic                      word_done_c;
  logic                      flush_c;
  logic                      expire_c;

`ifdef DESERIALIZER_TIMEOUT_EN
  deserializer_idle_timer #(
    .TIMEOUT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .active_i (cnt_q != '0),
    .clear_i  (data_val_i),
    .expire_c (expire_c)
  );
`else
  logic unused_idle_timeout;
  assign unused_idle_timeout = ^32'(IDLE_TIMEOUT);
  assign expire_c            = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (shift_en_c && !word_done_c) state_nxt = COLLECT;
      COLLECT: if (word_done_c || flush_c)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM-qualified control strobes
  always_comb begin
    shift_en_c  = 1'b0;
    word_done_c = 1'b0;
    flush_c     = 1'b0;
    case (state_q)
      IDLE: begin
        shift_en_c  = data_val_i;
        word_done_c = data_val_i && (cnt_q == LAST_CNT);
      end
      COLLECT: begin
        shift_en_c  = data_val_i;
        word_done_c = data_val_i && (cnt_q == LAST_CNT);
        flush_c     = expire_c;
      end
      default: ;
    endcase
  end

  // Shift/count datapath; a flush left-aligns the k held bits with zero LSBs.
  always_comb begin
    sr_nxt       = DATA_BUS_WIDTH'({sr_q, data_i});
    flush_word_c = sr_q << (DATA_BUS_WIDTH - 32'(cnt_q));
    cnt_nxt      = cnt_q;
    if (word_done_c || flush_c) begin
      cnt_nxt = '0;
    end else if (shift_en_c) begin
      cnt_nxt = cnt_q + DATA_MOD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      if (shift_en_c) begin
        sr_q <= sr_nxt;
      end
    end
  end

  // Output registers; word/mod hold their last value between pulses.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      deser_data_val_o <= word_done_c || flush_c;
      busy_o           <= (cnt_nxt != '0);
      if (word_done_c) begin
        deser_data_o     <= sr_nxt;
        deser_data_mod_o <= '0;
      end else if (flush_c) begin
        deser_data_o     <= flush_word_c;
        deser_data_mod_o <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer (honours DESERIALIZER_TIMEOUT_EN).
module tb_deserializer;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic        data_i;
  logic        data_val_i;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o;
  logic        busy_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          busy_err;
  int          base;
  int          pcyc[$];
  logic [15:0] pdata[$];
  logic [3:0]  pmod[$];

  deserializer #(
    .DATA_BUS_WIDTH (16),
    .DATA_MOD_WIDTH (4),
    .IDLE_TIMEOUT   (8)
  ) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Pulse recorder, sampled mid-cycle
  always @(negedge clk_i) begin
    if (deser_data_val_o) begin
      pcyc.push_back(cyc);
      pdata.push_back(deser_data_o);
      pmod.push_back(deser_data_mod_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Sends bits MSB-first from w[nbits-1]; busy_o must stay high until the last bit.
  task automatic send_bits(input logic [15:0] w, input int nbits, input int gap);
    for (int i = nbits - 1; i >= 0; i--) begin
      data_i     = w[i];
      data_val_i = 1'b1;
      tick(1);
      data_val_i = 1'b0;
      data_i     = 1'($urandom);
      if (i != 0 && !busy_o) busy_err++;
      for (int g = 0; g < gap; g++) begin
        tick(1);
        if (i != 0 && !busy_o) busy_err++;
      end
    end
  endtask

  initial begin
    srst_i     = 1'b1;
    data_i     = 1'b0;
    data_val_i = 1'b0;
    tick(3);
    check("rst_data", 32'(deser_data_o), 32'h0);
    check("rst_mod", 32'(deser_data_mod_o), 32'h0);
    check("rst_val", 32'(deser_data_val_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    srst_i = 1'b0;

    // Idle line with garbage data must do nothing
    base = pdata.size();
    for (int i = 0; i < 100; i++) begin
      data_i = 1'($urandom);
      tick(1);
    end
    check("t6_pulses", 32'(pdata.size() - base), 32'd0);
    check("t6_busy", 32'(busy_o), 32'h0);

    // Full word, no gaps
    base     = pdata.size();
    busy_err = 0;
    send_bits(16'hA5C3, 16, 0);
    check("t1_val", 32'(deser_data_val_o), 32'h1);
    check("t1_data", 32'(deser_data_o), 32'hA5C3);
    check("t1_mod", 32'(deser_data_mod_o), 32'h0);
    check("t1_busy", 32'(busy_o), 32'h0);
    tick(1);
    check("t1_val_drop", 32'(deser_data_val_o), 32'h0);
    check("t1_data_hold", 32'(deser_data_o), 32'hA5C3);
    tick(3);
    check("t1_pulses", 32'(pdata.size() - base), 32'd1);
    check("t1_busy_err", 32'(busy_err), 32'd0);

    // Same word with 3-cycle gaps between bits
    base     = pdata.size();
    busy_err = 0;
    send_bits(16'hA5C3, 16, 3);
    tick(2);
    check("t2_pulses", 32'(pdata.size() - base), 32'd1);
    if (pdata.size() > base) begin
      check("t2_data", 32'(pdata[base]), 32'hA5C3);
      check("t2_mod", 32'(pmod[base]), 32'h0);
    end
    check("t2_busy_err", 32'(busy_err), 32'd0);
    check("t2_busy_end", 32'(busy_o), 32'h0);

    // Back-to-back words
    base = pdata.size();
    send_bits(16'h1234, 16, 0);
    send_bits(16'hFFFF, 16, 0);
    tick(3);
    check("t3_pulses", 32'(pdata.size() - base), 32'd2);
    if (pdata.size() >= base + 2) begin
      check("t3_data0", 32'(pdata[base]), 32'h1234);
      check("t3_data1", 32'(pdata[base+1]), 32'hFFFF);
      check("t3_spacing", 32'(pcyc[base+1] - pcyc[base]), 32'd16);
    end

    // Reset mid-word discards bits and clears held outputs
    base = pdata.size();
    send_bits(16'h007F, 7, 0);
    check("t4_busy_pre", 32'(busy_o), 32'h1);
    srst_i = 1'b1;
    tick(1);
    srst_i = 1'b0;
    check("t4_rst_busy", 32'(busy_o), 32'h0);
    check("t4_rst_data", 32'(deser_data_o), 32'h0);
    send_bits(16'h00FF, 16, 0);
    tick(3);
    check("t4_pulses", 32'(pdata.size() - base), 32'd1);
    if (pdata.size() > base) check("t4_data", 32'(pdata[base]), 32'h00FF);

    // Partial word then idle gap
    base = pdata.size();
    send_bits(16'h0016, 5, 0);
    tick(7);
    check("t5_val_early", 32'(deser_data_val_o), 32'h0);
    check("t5_busy_early", 32'(busy_o), 32'h1);
    tick(1);
`ifdef DESERIALIZER_TIMEOUT_EN
    check("t5_val", 32'(deser_data_val_o), 32'h1);
    check("t5_data", 32'(deser_data_o), 32'hB000);
    check("t5_mod", 32'(deser_data_mod_o), 32'h5);
    check("t5_busy", 32'(busy_o), 32'h0);
    tick(20);
    check("t5_pulses", 32'(pdata.size() - base), 32'd1);
`else
    check("t5_val", 32'(deser_data_val_o), 32'h0);
    tick(20);
    check("t5_pulses", 32'(pdata.size() - base), 32'd0);
    check("t5_busy", 32'(busy_o), 32'h1);
    check("t5_mod", 32'(deser_data_mod_o), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
